// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_e              : arbiter FSM states (IDLE, ACCESS, DONE)
//   REQ_*                : requester ids, also the encoding of the grant output
//   STARVE_LIMIT_DEFAULT : fetch losses tolerated before fetch is forced to win
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam logic [1:0] REQ_LD    = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_STACK = 2'd2;
  localparam logic [1:0] REQ_FETCH = 2'd3;
  localparam int STARVE_LIMIT_DEFAULT = 3;
endpackage

// File: rtl/arb_priority_pick.sv
// arb_priority_pick: combinational winner selection for the memory port.
//   ld_req_i, data_req_i, stack_req_i, fetch_req_i : pending requests
//   load_mode_i  : only the loader is eligible when high; the loader is ignored when low
//   at_limit_i   : fetch has lost enough picks in a row and must win if it requests
//   valid_o      : some eligible requester is asking
//   winner_o     : id of the winning requester (REQ_* encoding)
module arb_priority_pick
  import mem_arb_pkg::*;
(
  input  logic       ld_req_i,
  input  logic       data_req_i,
  input  logic       stack_req_i,
  input  logic       fetch_req_i,
  input  logic       load_mode_i,
  input  logic       at_limit_i,
  output logic       valid_o,
  output logic [1:0] winner_o
);
  always_comb begin
    valid_o  = load_mode_i ? ld_req_i : (data_req_i | stack_req_i | fetch_req_i);
    winner_o = load_mode_i                ? REQ_LD    :
               (fetch_req_i && at_limit_i) ? REQ_FETCH :
               data_req_i                 ? REQ_DATA  :
               stack_req_i                ? REQ_STACK : REQ_FETCH;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: req/ack sequencer sharing one synchronous memory port among four requesters.
//   clk, reset        : clock and synchronous active-high reset
//   load_mode         : loader-only mode, sampled at each IDLE pick
//   ld_*              : loader write requester (always writes)
//   data_*, stack_*   : read/write requesters
//   fetch_*           : instruction read requester (always reads)
//   *_ack             : one-cycle completion pulses, two cycles after the pick
//   rdata             : memory read data, zero unless an ack is high
//   grant             : registered id of the current/last winner
//   busy              : high while an access is in ACCESS or DONE
//   mem_addr/mem_we/mem_din/mem_dout : memory port, 1-cycle synchronous read
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_mode,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_ack,
  input  logic          stack_req,
  input  logic          stack_we,
  input  logic [AW-1:0] stack_addr,
  input  logic [DW-1:0] stack_wdata,
  output logic          stack_ack,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          pick_valid, at_limit, take, done;
  logic [1:0]    pick_id;

  assign at_limit = starve_q == 2'(STARVE_LIMIT);
  assign take     = state_q == IDLE && pick_valid;

  arb_priority_pick u_pick (
    .ld_req_i    (ld_req),
    .data_req_i  (data_req),
    .stack_req_i (stack_req),
    .fetch_req_i (fetch_req),
    .load_mode_i (load_mode),
    .at_limit_i  (at_limit),
    .valid_o     (pick_valid),
    .winner_o    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= REQ_LD;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q == IDLE   ? (pick_valid ? ACCESS : IDLE) :
              state_q == ACCESS ? DONE : IDLE;
  end

  // Operands are captured only at a pick so the port stays stable for the whole access.
  always_comb begin
    grant_d  = take ? pick_id : grant_q;
    addr_d   = !take                 ? addr_q     :
               pick_id == REQ_LD     ? ld_addr    :
               pick_id == REQ_DATA   ? data_addr  :
               pick_id == REQ_STACK  ? stack_addr : fetch_addr;
    we_d     = !take                 ? we_q       :
               pick_id == REQ_LD     ? 1'b1       :
               pick_id == REQ_DATA   ? data_we    :
               pick_id == REQ_STACK  ? stack_we   : 1'b0;
    wdata_d  = !take                 ? wdata_q    :
               pick_id == REQ_LD     ? ld_wdata   :
               pick_id == REQ_DATA   ? data_wdata :
               pick_id == REQ_STACK  ? stack_wdata : '0;
    // Counts picks fetch asked for but lost, including loader-mode picks.
    starve_d = !(take && fetch_req)  ? starve_q   :
               pick_id == REQ_FETCH  ? 2'd0       :
               starve_q == 2'd3      ? 2'd3       : starve_q + 2'd1;
  end

  always_comb begin
    done      = state_q == DONE && !reset;
    ld_ack    = done && grant_q == REQ_LD;
    data_ack  = done && grant_q == REQ_DATA;
    stack_ack = done && grant_q == REQ_STACK;
    fetch_ack = done && grant_q == REQ_FETCH;
    rdata     = done ? mem_dout : '0;
    grant     = grant_q;
    busy      = state_q != IDLE;
    mem_addr  = addr_q;
    mem_din   = wdata_q;
    mem_we    = state_q == ACCESS && we_q && !reset;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with an ack scoreboard against a behavioural memory.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset, load_mode, mem_init;
  logic        ld_req, data_req, data_we, stack_req, stack_we, fetch_req;
  logic [15:0] ld_addr, ld_wdata, data_addr, data_wdata, stack_addr, stack_wdata, fetch_addr;
  logic        ld_ack, data_ack, stack_ack, fetch_ack, busy, mem_we;
  logic [15:0] rdata, mem_addr, mem_din, mem_dout;
  logic [1:0]  grant;
  logic [15:0] mem [0:255];

  typedef struct {
    logic [3:0]  ack;
    logic        rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [3:0] acks;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset), .load_mode(load_mode),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
    .stack_req(stack_req), .stack_we(stack_we), .stack_addr(stack_addr), .stack_wdata(stack_wdata), .stack_ack(stack_ack),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hA5C3;
      mem[8'h20] <= 16'h0F0F;
      mem[8'h30] <= 16'h3333;
      mem[8'h41] <= 16'h5A5A;
      mem[8'hFF] <= 16'h1111;
    end else if (mem_we) mem[mem_addr[7:0]] <= mem_din;
    mem_dout <= mem[mem_addr[7:0]];
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, busy, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl grant=%0d busy=%b mem_we=%b need 0/0/0", grant, busy, mem_we);
    end
    checks++;
    if ({mem_addr, mem_din, rdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_port addr=%h din=%h rdata=%h need 0", mem_addr, mem_din, rdata);
    end
    checks++;
    if ({ld_ack, data_ack, stack_ack, fetch_ack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_acks got=%b need 0000", {ld_ack, data_ack, stack_ack, fetch_ack});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, busy, mem_we, mem_addr} !== 20'h0) begin
      errors++;
      $display("FAIL reset_release grant=%0d busy=%b we=%b addr=%h need all 0", grant, busy, mem_we, mem_addr);
    end
  endtask

  task automatic test_single_fetch();
    @(posedge clk);
    #1 fetch_req = 1'b1; fetch_addr = 16'h0010;
    exp_q.push_back('{ack: 4'b1000, rd: 1'b1, rdata: 16'hA5C3});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acks = {fetch_ack, stack_ack, data_ack, ld_ack};
      if (acks !== 4'b0) begin
        checks++;
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '{ack: 4'b0, rd: 1'b0, rdata: 16'h0};
        if (acks !== e.ack || (e.rd && rdata !== e.rdata)) begin
          errors++;
          $display("FAIL sb_fetch c=%0d acks=%b rdata=%h need acks=%b rdata=%h", c, acks, rdata, e.ack, e.rdata);
        end
      end
      checks++;
      if (busy !== (c == 1 || c == 2) || fetch_ack !== (c == 2)) begin
        errors++;
        $display("FAIL fetch_timing c=%0d busy=%b ack=%b need busy=%b ack=%b", c, busy, fetch_ack, c == 1 || c == 2, c == 2);
      end
      if (c >= 1) begin
        checks++;
        if (grant !== 2'd3) begin
          errors++;
          $display("FAIL fetch_grant c=%0d got=%0d need 3", c, grant);
        end
      end
      @(posedge clk);
      #1 if (c == 2) fetch_req = 1'b0;
    end
  endtask

  task automatic test_data_then_stack();
    @(posedge clk);
    #1 data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0040; data_wdata = 16'h1234;
    stack_req = 1'b1; stack_we = 1'b0; stack_addr = 16'h0041;
    exp_q.push_back('{ack: 4'b0010, rd: 1'b0, rdata: 16'h0});
    exp_q.push_back('{ack: 4'b0100, rd: 1'b1, rdata: 16'h5A5A});
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      acks = {fetch_ack, stack_ack, data_ack, ld_ack};
      if (acks !== 4'b0) begin
        checks++;
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '{ack: 4'b0, rd: 1'b0, rdata: 16'h0};
        if (acks !== e.ack || (e.rd && rdata !== e.rdata)) begin
          errors++;
          $display("FAIL sb_data_stack c=%0d acks=%b rdata=%h need acks=%b rdata=%h", c, acks, rdata, e.ack, e.rdata);
        end
      end
      checks++;
      if (mem_we !== (c == 1) || data_ack !== (c == 2) || stack_ack !== (c == 5)) begin
        errors++;
        $display("FAIL ds_timing c=%0d we=%b dack=%b sack=%b need %b/%b/%b", c, mem_we, data_ack, stack_ack, c == 1, c == 2, c == 5);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 16'h0040 || mem_din !== 16'h1234) begin
          errors++;
          $display("FAIL ds_port addr=%h din=%h need 0040/1234", mem_addr, mem_din);
        end
      end
      if (c == 4) begin
        checks++;
        if (grant !== 2'd2) begin
          errors++;
          $display("FAIL ds_grant got=%0d need 2", grant);
        end
      end
      @(posedge clk);
      #1 if (c == 2) data_req = 1'b0;
      if (c == 5) stack_req = 1'b0;
    end
    checks++;
    if (mem[8'h40] !== 16'h1234) begin
      errors++;
      $display("FAIL ds_mem got=%h need 1234", mem[8'h40]);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] seq [9];
    seq = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1};
    @(posedge clk);
    #1 data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0030;
    fetch_req = 1'b1; fetch_addr = 16'h0020;
    for (int k = 0; k < 9; k++)
      if (seq[k] == 2'd3) exp_q.push_back('{ack: 4'b1000, rd: 1'b1, rdata: 16'h0F0F});
      else exp_q.push_back('{ack: 4'b0010, rd: 1'b1, rdata: 16'h3333});
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      acks = {fetch_ack, stack_ack, data_ack, ld_ack};
      if (acks !== 4'b0) begin
        checks++;
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '{ack: 4'b0, rd: 1'b0, rdata: 16'h0};
        if (acks !== e.ack || (e.rd && rdata !== e.rdata)) begin
          errors++;
          $display("FAIL sb_starve c=%0d acks=%b rdata=%h need acks=%b rdata=%h", c, acks, rdata, e.ack, e.rdata);
        end
      end
      if (c % 3 == 1) begin
        checks++;
        if (grant !== seq[c/3]) begin
          errors++;
          $display("FAIL starve_grant pick=%0d got=%0d need %0d", c / 3 + 1, grant, seq[c/3]);
        end
      end
      @(posedge clk);
      #1 if (c == 23) fetch_req = 1'b0;
      if (c == 26) data_req = 1'b0;
    end
  endtask

  task automatic test_load_mode();
    @(posedge clk);
    #1 load_mode = 1'b1; ld_req = 1'b1; ld_addr = 16'h0000; ld_wdata = 16'hBEEF;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0030;
    fetch_req = 1'b1; fetch_addr = 16'h0020;
    exp_q.push_back('{ack: 4'b0001, rd: 1'b0, rdata: 16'h0});
    exp_q.push_back('{ack: 4'b0010, rd: 1'b1, rdata: 16'h3333});
    exp_q.push_back('{ack: 4'b1000, rd: 1'b1, rdata: 16'h0F0F});
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      acks = {fetch_ack, stack_ack, data_ack, ld_ack};
      if (acks !== 4'b0) begin
        checks++;
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '{ack: 4'b0, rd: 1'b0, rdata: 16'h0};
        if (acks !== e.ack || (e.rd && rdata !== e.rdata)) begin
          errors++;
          $display("FAIL sb_load c=%0d acks=%b rdata=%h need acks=%b rdata=%h", c, acks, rdata, e.ack, e.rdata);
        end
      end
      checks++;
      if (ld_ack !== (c == 2) || data_ack !== (c == 7) || fetch_ack !== (c == 10)) begin
        errors++;
        $display("FAIL load_timing c=%0d ld=%b data=%b fetch=%b need %b/%b/%b", c, ld_ack, data_ack, fetch_ack, c == 2, c == 7, c == 10);
      end
      if (c == 1 || c == 3 || c == 4) begin
        checks++;
        if (busy !== (c == 1) || (c == 1 && grant !== 2'd0)) begin
          errors++;
          $display("FAIL load_state c=%0d busy=%b grant=%0d need busy=%b grant=0", c, busy, grant, c == 1);
        end
      end
      @(posedge clk);
      #1 if (c == 2) ld_req = 1'b0;
      if (c == 4) load_mode = 1'b0;
      if (c == 7) data_req = 1'b0;
      if (c == 10) fetch_req = 1'b0;
    end
    checks++;
    if (mem[8'h00] !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_mem got=%h need BEEF", mem[8'h00]);
    end
  endtask

  task automatic test_reset_in_access();
    @(posedge clk);
    #1 stack_req = 1'b1; stack_we = 1'b1; stack_addr = 16'h00FF; stack_wdata = 16'h7777;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acks = {fetch_ack, stack_ack, data_ack, ld_ack};
      if (acks !== 4'b0) begin
        checks++;
        if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '{ack: 4'b0, rd: 1'b0, rdata: 16'h0};
        if (acks !== e.ack) begin
          errors++;
          $display("FAIL sb_rst_access c=%0d acks=%b need %b", c, acks, e.ack);
        end
      end
      if (c == 1) begin
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_access_we we=%b busy=%b need 0/1", mem_we, busy);
        end
      end
      if (c == 2) begin
        checks++;
        if ({grant, busy, mem_we, mem_addr, mem_din, rdata, acks} !== 56'h0) begin
          errors++;
          $display("FAIL rst_access_out grant=%0d busy=%b we=%b addr=%h din=%h rdata=%h acks=%b need all 0",
                   grant, busy, mem_we, mem_addr, mem_din, rdata, acks);
        end
      end
      @(posedge clk);
      #1 if (c == 0) reset = 1'b1;
      if (c == 1) begin reset = 1'b0; stack_req = 1'b0; end
    end
    checks++;
    if (mem[8'hFF] !== 16'h1111) begin
      errors++;
      $display("FAIL rst_access_mem got=%h need 1111", mem[8'hFF]);
    end
  endtask

  task automatic test_reset_in_done();
    @(posedge clk);
    #1 fetch_req = 1'b1; fetch_addr = 16'h0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acks = {fetch_ack, stack_ack, data_ack, ld_ack};
      checks++;
      if (acks !== 4'b0 || rdata !== 16'h0) begin
        errors++;
        $display("FAIL rst_done c=%0d acks=%b rdata=%h need 0000/0000", c, acks, rdata);
      end
      @(posedge clk);
      #1 if (c == 1) reset = 1'b1;
      if (c == 2) begin reset = 1'b0; fetch_req = 1'b0; end
    end
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1; load_mode = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    stack_req = 1'b0; stack_we = 1'b0; stack_addr = '0; stack_wdata = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    test_reset();
    test_single_fetch();
    test_data_then_stack();
    test_starvation();
    test_load_mode();
    test_reset_in_access();
    test_reset_in_done();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
